// File: rtl/button_debounce_if.sv
// Push-button signal bundle: raw pin in, conditioned level and event pulses out.
interface button_debounce_if;
    logic btn_in;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_press;

    modport master (
        output btn_in,
        input  btn_level,
        input  press_pulse,
        input  release_pulse,
        input  long_press
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output press_pulse,
        output release_pulse,
        output long_press
    );
endinterface

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop synchroniser, counter debounce FSM,
// registered press/release pulses and a one-shot long-press pulse.
module button_debounce #(
    parameter int unsigned STABLE_COUNT = 1000000,
    parameter int unsigned LONG_COUNT   = 50000000,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    button_debounce_if.slave  bif
);

    localparam int unsigned CW = $clog2(STABLE_COUNT + 1);
    localparam int unsigned HW = $clog2(LONG_COUNT + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_COUNT - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_COUNT - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_COUNT);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        PRESSED,
        RELEASE_PEND
    } state_e;

    logic          raw;
    logic          sync1_q, sync1_d;
    logic          btn_s_q, btn_s_d;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;

    // Normalise polarity so that 1 always means pressed from here on.
    assign raw = ACTIVE_LOW ? ~bif.btn_in : bif.btn_in;

    always_comb begin
        sync1_d = raw;
        btn_s_d = sync1_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RELEASED: begin
                if (btn_s_q) begin
                    if (STABLE_COUNT == 1) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else begin
                        state_d = PRESS_PEND;
                        cnt_d   = CW'(1);
                    end
                end
            end
            PRESS_PEND: begin
                if (!btn_s_q) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!btn_s_q) begin
                    if (STABLE_COUNT == 1) begin
                        state_d = RELEASED;
                        cnt_d   = '0;
                    end else begin
                        state_d = RELEASE_PEND;
                        cnt_d   = CW'(1);
                    end
                end
            end
            RELEASE_PEND: begin
                if (btn_s_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    // Level lags the state by one register; pulses mark its edges.
    // hold_q is held at zero whenever level is low, which covers both the
    // clear on entry to PRESSED and the re-arm on release.
    always_comb begin
        level_d   = (state_q == PRESSED) || (state_q == RELEASE_PEND);
        press_d   = level_d & ~level_q;
        release_d = ~level_d & level_q;
        hold_d    = hold_q;
        if (!level_q) begin
            hold_d = '0;
        end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
        end
        long_d = level_q && (hold_q == HOLD_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            btn_s_q   <= 1'b0;
            state_q   <= RELEASED;
            cnt_q     <= '0;
            hold_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            btn_s_q   <= btn_s_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    assign bif.btn_level     = level_q;
    assign bif.press_pulse   = press_q;
    assign bif.release_pulse = release_q;
    assign bif.long_press    = long_q;

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: active-low and active-high instances driven with
// mirrored stimulus and compared every cycle against a run-length reference model.
module tb_button_debounce;

    localparam int STABLE = 4;
    localparam int LONG   = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    button_debounce_if bif_al ();
    button_debounce_if bif_ah ();

    button_debounce #(.STABLE_COUNT(STABLE), .LONG_COUNT(LONG), .ACTIVE_LOW(1'b1)) dut_al (
        .clk   (clk),
        .rst_n (rst_n),
        .bif   (bif_al)
    );

    button_debounce #(.STABLE_COUNT(STABLE), .LONG_COUNT(LONG), .ACTIVE_LOW(1'b0)) dut_ah (
        .clk   (clk),
        .rst_n (rst_n),
        .bif   (bif_ah)
    );

    always #5 clk = ~clk;

    // {btn_level, press_pulse, release_pulse, long_press}
    logic [3:0] obs_al, obs_ah;
    assign obs_al = {bif_al.btn_level, bif_al.press_pulse, bif_al.release_pulse, bif_al.long_press};
    assign obs_ah = {bif_ah.btn_level, bif_ah.press_pulse, bif_ah.release_pulse, bif_ah.long_press};

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: pressed history, accepted level, run length of the
    // disagreeing synchronised value, and length of the current high level.
    bit         s1, s2, acc, lvl;
    int         run, lrun;
    logic [3:0] exp_v;

    task automatic model_reset();
        s1 = 0; s2 = 0; acc = 0; lvl = 0;
        run = 0; lrun = 0; exp_v = '0;
    endtask

    // Called at a negedge; applies one cycle of button state and returns at the next negedge.
    task automatic tick(input bit p);
        bit bs, nl, el;
        bif_al.btn_in = ~p;
        bif_ah.btn_in = p;
        @(posedge clk);
        bs = s2;
        s2 = s1;
        s1 = p;
        nl = acc;
        el = (lrun == LONG);
        if (bs != acc) begin
            run++;
            if (run == STABLE) begin
                acc = bs;
                run = 0;
            end
        end else begin
            run = 0;
        end
        exp_v = {nl, nl & ~lvl, ~nl & lvl, el};
        lrun  = nl ? lrun + 1 : 0;
        lvl   = nl;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bif_al.btn_in = 1'b1;
        bif_ah.btn_in = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (obs_al !== 4'b0000) begin n_fail++; $display("FAIL reset_al got=%b exp=0000", obs_al); end
        n_chk++;
        if (obs_ah !== 4'b0000) begin n_fail++; $display("FAIL reset_ah got=%b exp=0000", obs_ah); end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            tick(1'b0);
            n_chk++;
            if (obs_al !== exp_v) begin n_fail++; $display("FAIL idle_al i=%0d got=%b exp=%b", i, obs_al, exp_v); end
            n_chk++;
            if (obs_ah !== exp_v) begin n_fail++; $display("FAIL idle_ah i=%0d got=%b exp=%b", i, obs_ah, exp_v); end
        end
    endtask

    task automatic test_clean_press();
        int press_idx = -1;
        for (int i = 0; i < 12; i++) begin
            tick(1'b1);
            n_chk++;
            if (obs_al !== exp_v) begin n_fail++; $display("FAIL clean_al i=%0d got=%b exp=%b", i, obs_al, exp_v); end
            n_chk++;
            if (obs_ah !== exp_v) begin n_fail++; $display("FAIL clean_ah i=%0d got=%b exp=%b", i, obs_ah, exp_v); end
            if (obs_al[2] && press_idx < 0) press_idx = i;
        end
        n_chk++;
        if (press_idx != 6) begin n_fail++; $display("FAIL clean_latency got=%0d exp=6", press_idx); end
        for (int i = 0; i < 12; i++) begin
            tick(1'b0);
            n_chk++;
            if (obs_al !== exp_v) begin n_fail++; $display("FAIL clean_rel_al i=%0d got=%b exp=%b", i, obs_al, exp_v); end
            n_chk++;
            if (obs_ah !== exp_v) begin n_fail++; $display("FAIL clean_rel_ah i=%0d got=%b exp=%b", i, obs_ah, exp_v); end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] any_out = '0;
        for (int i = 0; i < 15; i++) begin
            tick(i < 3);
            n_chk++;
            if (obs_al !== exp_v) begin n_fail++; $display("FAIL bounce_al i=%0d got=%b exp=%b", i, obs_al, exp_v); end
            n_chk++;
            if (obs_ah !== exp_v) begin n_fail++; $display("FAIL bounce_ah i=%0d got=%b exp=%b", i, obs_ah, exp_v); end
            any_out = any_out | obs_al | obs_ah;
        end
        n_chk++;
        if (any_out[3:1] !== 3'b000) begin n_fail++; $display("FAIL bounce_quiet got=%b exp=000", any_out[3:1]); end
    endtask

    task automatic test_bounce_press();
        bit pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int presses = 0;
        int press_idx = -1;
        for (int i = 0; i < 20; i++) begin
            tick(i < 5 ? pat[i] : 1'b1);
            n_chk++;
            if (obs_al !== exp_v) begin n_fail++; $display("FAIL bpress_al i=%0d got=%b exp=%b", i, obs_al, exp_v); end
            n_chk++;
            if (obs_ah !== exp_v) begin n_fail++; $display("FAIL bpress_ah i=%0d got=%b exp=%b", i, obs_ah, exp_v); end
            if (obs_al[2]) begin presses++; press_idx = i; end
        end
        n_chk++;
        if (presses != 1 || press_idx != 11) begin
            n_fail++; $display("FAIL bpress_once got=%0d@%0d exp=1@11", presses, press_idx);
        end
        for (int i = 0; i < 15; i++) begin
            tick(1'b0);
            n_chk++;
            if (obs_al !== exp_v) begin n_fail++; $display("FAIL bpress_rel_al i=%0d got=%b exp=%b", i, obs_al, exp_v); end
        end
    endtask

    task automatic test_long_press();
        int press_idx = -1, long_idx = -1, longs = 0, rel_idx = -1, rels = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1'b1);
            n_chk++;
            if (obs_al !== exp_v) begin n_fail++; $display("FAIL long_al i=%0d got=%b exp=%b", i, obs_al, exp_v); end
            n_chk++;
            if (obs_ah !== exp_v) begin n_fail++; $display("FAIL long_ah i=%0d got=%b exp=%b", i, obs_ah, exp_v); end
            if (obs_al[2] && press_idx < 0) press_idx = i;
            if (obs_al[0]) begin longs++; long_idx = i; end
        end
        n_chk++;
        if (longs != 1 || long_idx - press_idx != 10) begin
            n_fail++; $display("FAIL long_once got=%0d gap=%0d exp=1 gap=10", longs, long_idx - press_idx);
        end
        for (int i = 0; i < 12; i++) begin
            tick(1'b0);
            n_chk++;
            if (obs_al !== exp_v) begin n_fail++; $display("FAIL long_rel_al i=%0d got=%b exp=%b", i, obs_al, exp_v); end
            n_chk++;
            if (obs_ah !== exp_v) begin n_fail++; $display("FAIL long_rel_ah i=%0d got=%b exp=%b", i, obs_ah, exp_v); end
            if (obs_al[1]) begin rels++; rel_idx = i; end
        end
        n_chk++;
        if (rels != 1 || rel_idx != 6) begin n_fail++; $display("FAIL long_release got=%0d@%0d exp=1@6", rels, rel_idx); end
    endtask

    task automatic test_short_hold();
        int hi = 0, longs1 = 0, rels = 0, press_idx = -1, long_idx = -1;
        for (int i = 0; i < 12; i++) begin
            tick(i < 5);
            n_chk++;
            if (obs_al !== exp_v) begin n_fail++; $display("FAIL short_al i=%0d got=%b exp=%b", i, obs_al, exp_v); end
            n_chk++;
            if (obs_ah !== exp_v) begin n_fail++; $display("FAIL short_ah i=%0d got=%b exp=%b", i, obs_ah, exp_v); end
            if (obs_al[3]) hi++;
            if (obs_al[0]) longs1++;
            if (obs_al[1]) rels++;
        end
        n_chk++;
        if (hi != 5 || longs1 != 0 || rels != 1) begin
            n_fail++; $display("FAIL short_hold got hi=%0d long=%0d rel=%0d exp hi=5 long=0 rel=1", hi, longs1, rels);
        end
        for (int i = 0; i < 30; i++) begin
            tick(1'b1);
            n_chk++;
            if (obs_al !== exp_v) begin n_fail++; $display("FAIL repress_al i=%0d got=%b exp=%b", i, obs_al, exp_v); end
            n_chk++;
            if (obs_ah !== exp_v) begin n_fail++; $display("FAIL repress_ah i=%0d got=%b exp=%b", i, obs_ah, exp_v); end
            if (obs_al[2] && press_idx < 0) press_idx = i;
            if (obs_al[0] && long_idx < 0) long_idx = i;
        end
        n_chk++;
        if (press_idx < 0 || long_idx - press_idx != 10) begin
            n_fail++; $display("FAIL repress_long got press=%0d long=%0d exp gap=10", press_idx, long_idx);
        end
        for (int i = 0; i < 12; i++) tick(1'b0);
    endtask

    task automatic test_reset_mid_press();
        int press_idx = -1;
        for (int i = 0; i < 10; i++) tick(1'b1);
        n_chk++;
        if (obs_al[3] !== 1'b1) begin n_fail++; $display("FAIL midrst_pressed got=%b exp=1", obs_al[3]); end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (obs_al !== 4'b0000) begin n_fail++; $display("FAIL midrst_al got=%b exp=0000", obs_al); end
        n_chk++;
        if (obs_ah !== 4'b0000) begin n_fail++; $display("FAIL midrst_ah got=%b exp=0000", obs_ah); end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 12; i++) begin
            tick(1'b1);
            n_chk++;
            if (obs_al !== exp_v) begin n_fail++; $display("FAIL midrst_re_al i=%0d got=%b exp=%b", i, obs_al, exp_v); end
            n_chk++;
            if (obs_ah !== exp_v) begin n_fail++; $display("FAIL midrst_re_ah i=%0d got=%b exp=%b", i, obs_ah, exp_v); end
            if (obs_al[2] && press_idx < 0) press_idx = i;
        end
        n_chk++;
        if (press_idx != 6) begin n_fail++; $display("FAIL midrst_latency got=%0d exp=6", press_idx); end
        for (int i = 0; i < 12; i++) tick(1'b0);
    endtask

    task automatic test_random();
        bit p = 1'b0;
        int left = 0;
        for (int i = 0; i < 400; i++) begin
            if (left == 0) begin
                p = ~p;
                left = int'($urandom_range(1, 15));
            end
            left--;
            tick(p);
            n_chk++;
            if (obs_al !== exp_v) begin n_fail++; $display("FAIL rand_al i=%0d got=%b exp=%b", i, obs_al, exp_v); end
            n_chk++;
            if (obs_ah !== exp_v) begin n_fail++; $display("FAIL rand_ah i=%0d got=%b exp=%b", i, obs_ah, exp_v); end
        end
        for (int i = 0; i < 20; i++) tick(1'b0);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_bounce_press();
        test_long_press();
        test_short_hold();
        test_reset_mid_press();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
